frame_painter: RTL and testbench

Frame-buffer write stage that renders one game frame on request from the NIOS software. On a start handshake it fills the whole 640x480 8-bit frame buffer with a background colour. It then rasterises up to NUM_OBJ solid square veggie sprites described by the software port words. It drives the frame buffer's write side (data, write address, write enable) while the frame displayer reads the other port independently.

---
 rtl/frame_painter.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_frame_painter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_painter.sv
// frame_painter: frame-buffer write stage.
//
// On a rising edge of start (seen only while idle) the block fills the whole
// H_RES x V_RES 8-bit buffer with BG_COLOR, then rasterises up to NUM_OBJ
// solid squares taken from obj_words.
//
// Object word layout: [9:0] x, [18:10] y, [23:19] size code s, [31:24] colour.
// The side of the square is 4*(s+1). Colour 0 skips the object.
//
// Objects are drawn in index order, so a higher index overwrites a lower one.
// Pixels falling outside the visible area are clipped (no write), but their
// cycles are still spent.
//
// Handshake: start is a level. A low->high transition is accepted only in
// IDLE. done is held in DONE until start is seen low.
//
// Ports:
//   Clk        system clock
//   Reset      asynchronous, active-high reset
//   start      frame request level
//   obj_words  NUM_OBJ packed 32-bit object descriptors
//   wr_data    buffer write data       (registered)
//   wr_addr    buffer write address    (registered, y*H_RES + x)
//   wr_en      buffer write enable     (registered)
//   busy       frame in progress       (registered)
//   done       frame complete          (registered)
//   dbg_state  current FSM state, for observation only
module frame_painter #(
    parameter int          H_RES    = 640,
    parameter int          V_RES    = 480,
    parameter int          NUM_OBJ  = 10,
    parameter logic [7:0]  BG_COLOR = 8'h1C
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    start,
    input  logic [NUM_OBJ*32-1:0]   obj_words,
    output logic [7:0]              wr_data,
    output logic [18:0]             wr_addr,
    output logic                    wr_en,
    output logic                    busy,
    output logic                    done,
    output logic [2:0]              dbg_state
);

    localparam int          IW       = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam logic [18:0] LAST_PIX = 19'(H_RES * V_RES - 1);
    localparam logic [IW-1:0] LAST_OBJ = IW'(NUM_OBJ - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_DRAW  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Registered state
    state_t        r_state;
    logic          r_start_q;
    logic          r_armed;      // start has been seen low since reset
    logic [18:0]   r_pix;
    logic [IW-1:0] r_idx;
    logic [9:0]    r_x0;
    logic [8:0]    r_y0;
    logic [6:0]    r_last;       // side - 1
    logic [7:0]    r_color;
    logic [6:0]    r_dx;
    logic [6:0]    r_dy;
    logic [19:0]   r_row_base;
    logic [7:0]    r_wr_data;
    logic [18:0]   r_wr_addr;
    logic          r_wr_en;
    logic          r_busy;
    logic          r_done;

    // Next-state values
    state_t        w_state_nxt;
    logic [18:0]   w_pix_nxt;
    logic [IW-1:0] w_idx_nxt;
    logic [9:0]    w_x0_nxt;
    logic [8:0]    w_y0_nxt;
    logic [6:0]    w_last_nxt;
    logic [7:0]    w_color_nxt;
    logic [6:0]    w_dx_nxt;
    logic [6:0]    w_dy_nxt;
    logic [19:0]   w_row_base_nxt;

    // Next output values
    logic [7:0]    w_wr_data_nxt;
    logic [18:0]   w_wr_addr_nxt;
    logic          w_wr_en_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;

    logic [31:0]   w_words [NUM_OBJ];
    logic [31:0]   w_word;
    logic          w_edge;
    logic [10:0]   w_px;
    logic [10:0]   w_py;

    always_comb begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            w_words[i] = obj_words[32*i +: 32];
        end
    end

    assign w_word = w_words[r_idx];

    // An edge needs start to have been seen low first, so a start already
    // high when Reset releases does not launch a frame.
    assign w_edge = start & ~r_start_q & r_armed;

    // ------------------------------------------------------------------
    // State register. The outputs are registered from the values of the
    // state being entered, so what the ports show always matches r_state.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_start_q  <= 1'b0;
            r_armed    <= 1'b0;
            r_pix      <= '0;
            r_idx      <= '0;
            r_x0       <= '0;
            r_y0       <= '0;
            r_last     <= '0;
            r_color    <= '0;
            r_dx       <= '0;
            r_dy       <= '0;
            r_row_base <= '0;
            r_wr_data  <= '0;
            r_wr_addr  <= '0;
            r_wr_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_start_q  <= start;
            r_armed    <= r_armed | ~start;
            r_pix      <= w_pix_nxt;
            r_idx      <= w_idx_nxt;
            r_x0       <= w_x0_nxt;
            r_y0       <= w_y0_nxt;
            r_last     <= w_last_nxt;
            r_color    <= w_color_nxt;
            r_dx       <= w_dx_nxt;
            r_dy       <= w_dy_nxt;
            r_row_base <= w_row_base_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_pix_nxt      = r_pix;
        w_idx_nxt      = r_idx;
        w_x0_nxt       = r_x0;
        w_y0_nxt       = r_y0;
        w_last_nxt     = r_last;
        w_color_nxt    = r_color;
        w_dx_nxt       = r_dx;
        w_dy_nxt       = r_dy;
        w_row_base_nxt = r_row_base;

        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_state_nxt = S_CLEAR;
                    w_pix_nxt   = '0;
                end
            end

            S_CLEAR: begin
                if (r_pix == LAST_PIX) begin
                    w_state_nxt = S_LOAD;
                    w_pix_nxt   = '0;
                    w_idx_nxt   = '0;
                end else begin
                    w_pix_nxt = r_pix + 19'd1;
                end
            end

            S_LOAD: begin
                // Snapshot the descriptor so later word changes do not
                // disturb an object in flight. side-1 = 4s+3 = {s,2'b11}.
                w_x0_nxt    = w_word[9:0];
                w_y0_nxt    = w_word[18:10];
                w_last_nxt  = {w_word[23:19], 2'b11};
                w_color_nxt = w_word[31:24];
                w_dx_nxt    = '0;
                w_dy_nxt    = '0;
                // Constant-coefficient product, once per object; rows after
                // the first are reached by adding H_RES.
                w_row_base_nxt = 20'(w_word[18:10]) * 20'(H_RES);
                if (w_word[31:24] == 8'h00) begin
                    if (r_idx == LAST_OBJ) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end else begin
                    w_state_nxt = S_DRAW;
                end
            end

            S_DRAW: begin
                if (r_dx == r_last) begin
                    w_dx_nxt = '0;
                    if (r_dy == r_last) begin
                        if (r_idx == LAST_OBJ) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_LOAD;
                            w_idx_nxt   = r_idx + IW'(1);
                        end
                    end else begin
                        w_dy_nxt       = r_dy + 7'd1;
                        w_row_base_nxt = r_row_base + 20'(H_RES);
                    end
                end else begin
                    w_dx_nxt = r_dx + 7'd1;
                end
            end

            S_DONE: begin
                if (!start) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (evaluated on the state being entered)
    // ------------------------------------------------------------------
    // 11-bit pixel coordinates so x0+dx / y0+dy never wrap before clipping.
    assign w_px = 11'(w_x0_nxt) + 11'(w_dx_nxt);
    assign w_py = 11'(w_y0_nxt) + 11'(w_dy_nxt);

    always_comb begin
        w_wr_data_nxt = '0;
        w_wr_addr_nxt = '0;
        w_wr_en_nxt   = 1'b0;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;

        case (w_state_nxt)
            S_CLEAR: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_data_nxt = BG_COLOR;
                w_wr_addr_nxt = w_pix_nxt;
                w_busy_nxt    = 1'b1;
            end
            S_LOAD: begin
                w_busy_nxt = 1'b1;
            end
            S_DRAW: begin
                w_busy_nxt    = 1'b1;
                w_wr_data_nxt = w_color_nxt;
                w_wr_addr_nxt = 19'(w_row_base_nxt + 20'(w_px));
                w_wr_en_nxt   = (w_px < 11'(H_RES)) && (w_py < 11'(V_RES));
            end
            S_DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign wr_data   = r_wr_data;
    assign wr_addr   = r_wr_addr;
    assign wr_en     = r_wr_en;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_frame_painter.sv
// Directed bench for frame_painter on a reduced 40x30 frame with 4 objects.
// Expected addresses are y*40 + x, computed by hand below.
module tb_frame_painter;
    localparam int H   = 40;
    localparam int V   = 30;
    localparam int N   = 4;
    localparam int CLR = H * V;   // 1200 clear cycles

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [N*32-1:0] obj_words;
    logic [7:0]      wr_data;
    logic [18:0]     wr_addr;
    logic            wr_en;
    logic            busy;
    logic            done;
    logic [2:0]      dbg_state;

    int n_cmp = 0;
    int n_mis = 0;

    // post-clear write log of the current frame
    logic [18:0] wa_q[$];
    logic [7:0]  wd_q[$];

    frame_painter #(
        .H_RES(H), .V_RES(V), .NUM_OBJ(N), .BG_COLOR(8'h1C)
    ) dut (
        .Clk(clk), .Reset(rst), .start(start), .obj_words(obj_words),
        .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int x, input int y, input int s, input int c);
        logic [31:0] w;
        w = '0;
        w[9:0]   = x[9:0];
        w[18:10] = y[8:0];
        w[23:19] = s[4:0];
        w[31:24] = c[7:0];
        return w;
    endfunction

    // Starts a frame, checks the clear pass, logs object writes, and returns
    // the number of cycles from the first write to done=1. With glitch set,
    // start is dropped and re-raised during the clear; that edge is ignored.
    task automatic do_frame(input bit glitch, output int lat);
        int clear_bad;
        int busy_bad;
        wa_q.delete();
        wd_q.delete();
        clear_bad = 0;
        busy_bad  = 0;
        lat       = 0;
        start = 1'b1;
        tick();
        chk("busy_rise", busy, 1);
        chk("first_addr", wr_addr, 0);
        for (int i = 0; i < CLR; i++) begin
            if (!(wr_en === 1'b1 && wr_addr === 19'(i) && wr_data === 8'h1C && busy === 1'b1))
                clear_bad++;
            if (glitch && i == 100) start = 1'b0;
            if (glitch && i == 101) start = 1'b1;
            tick();
            lat++;
        end
        chk("clear_run", clear_bad, 0);
        while (done !== 1'b1 && lat < CLR + 5000) begin
            if (busy !== 1'b1) busy_bad++;
            if (wr_en === 1'b1) begin
                wa_q.push_back(wr_addr);
                wd_q.push_back(wr_data);
            end
            tick();
            lat++;
        end
        chk("busy_draw", busy_bad, 0);
        chk("done_seen", done, 1);
        chk("busy_done", busy, 0);
    endtask

    // Holds start high in DONE, then drops it.
    task automatic end_frame();
        int bad;
        bad = 0;
        repeat (3) begin
            tick();
            if (done !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) bad++;
        end
        chk("done_hold", bad, 0);
        start = 1'b0;
        tick();
        chk("done_fall", done, 0);
        chk("idle_state", dbg_state, 0);
    endtask

    initial begin
        int lat;
        int bad;

        // ---------------- reset ----------------
        rst       = 1'b1;
        start     = 1'b0;
        obj_words = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        rst = 1'b0;
        tick();
        tick();
        chk("idle_quiet", wr_en, 0);

        // ---------------- clear only ----------------
        do_frame(1'b0, lat);
        chk("lat_clear", lat, CLR + N);
        chk("writes_clear", wa_q.size(), 0);
        end_frame();

        // ---------------- one object, edge ignored while busy ----------------
        obj_words = '0;
        obj_words[31:0] = mk(10, 5, 0, 'hE0);
        do_frame(1'b1, lat);
        chk("lat_one", lat, CLR + N + 16);
        chk("writes_one", wa_q.size(), 16);
        chk("one_first_addr", wa_q[0], 210);
        chk("one_first_data", wd_q[0], 'hE0);
        chk("one_row_end", wa_q[3], 213);
        chk("one_row_next", wa_q[4], 250);
        chk("one_last_addr", wa_q[15], 333);
        end_frame();

        // ---------------- clipping ----------------
        obj_words = '0;
        obj_words[31:0] = mk(34, 24, 3, 'h5A);
        do_frame(1'b0, lat);
        chk("lat_clip", lat, CLR + N + 256);
        chk("writes_clip", wa_q.size(), 36);
        chk("clip_first", wa_q[0], 994);
        chk("clip_row2", wa_q[6], 1034);
        chk("clip_last", wa_q[35], 1199);
        bad = 0;
        foreach (wa_q[i]) if (wa_q[i] >= 19'(CLR) || (wa_q[i] % 19'(H)) < 19'd34) bad++;
        chk("clip_bounds", bad, 0);
        end_frame();

        // ---------------- overlap, skip, fully clipped ----------------
        obj_words = '0;
        obj_words[31:0]   = mk(0, 0, 1, 'h11);
        obj_words[63:32]  = mk(3, 3, 2, 'h00);   // skipped
        obj_words[95:64]  = mk(4, 4, 0, 'h22);
        obj_words[127:96] = mk(1000, 2, 0, 'h33); // off the frame entirely
        do_frame(1'b0, lat);
        chk("lat_overlap", lat, CLR + N + 64 + 16 + 16);
        chk("writes_overlap", wa_q.size(), 80);
        chk("ovl_a_addr", wa_q[36], 164);
        chk("ovl_a_data", wd_q[36], 'h11);
        chk("ovl_b_addr", wa_q[64], 164);
        chk("ovl_b_data", wd_q[64], 'h22);
        chk("ovl_last", wa_q[79], 287);
        end_frame();

        // ---------------- reset mid-DRAW ----------------
        obj_words = '0;
        obj_words[31:0] = mk(0, 0, 7, 'h77);
        start = 1'b1;
        tick();
        repeat (CLR + 1 + 40) tick();
        chk("pre_rst_draw", dbg_state, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_wr_en", wr_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_addr", wr_addr, 0);
        tick();
        rst = 1'b0;
        bad = 0;
        repeat (10) begin
            tick();
            if (busy !== 1'b0 || wr_en !== 1'b0) bad++;
        end
        chk("no_start_held", bad, 0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        chk("restart_en", wr_en, 1);
        chk("restart_addr", wr_addr, 0);
        chk("restart_busy", busy, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
